// File: rtl/uart_pkg.sv
// Shared UART framing definitions for the transmitter and the receiver.
// Holds the FSM state enum, framing constants and the default bit period.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int FRAME_BYTES    = 2;

  // 50 MHz system clock, 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Ports: clock, reset (sync, high), clear (restart at 0), tick (last cycle of bit).
module uart_baud_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // A held clear keeps the counter at 0 and suppresses the tick.
  assign tick = (count == LAST) && !clear;

endmodule

// File: rtl/uart_tx_frame.sv
// Two-byte UART 8N1 frame transmitter, LSB first, byte 0 = command.
// Ports: clock, reset (sync, high), send_request, response_command,
// response_value in; busy, tx_serial, frame_done (all registered) out.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int NUM_BYTES    = FRAME_BYTES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_request,
  input  logic [7:0] response_command,
  input  logic [7:0] response_value,
  output logic       busy,
  output logic       tx_serial,
  output logic       frame_done
);

  localparam int BUF_W = UART_DATA_BITS * FRAME_BYTES;
  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       LAST_BYTE = 1'(NUM_BYTES - 1);

  uart_state_t      state;
  logic [BUF_W-1:0] shift_buf;
  logic [2:0]       bit_idx;
  logic             byte_idx;
  logic             tick;
  logic             clear;

  // Timer is held at 0 while idle, so the start bit gets a full period.
  // Every later state change happens on a tick, where the timer wraps.
  assign clear = (state == IDLE);

  uart_baud_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tx_serial  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shift_buf  <= '0;
      bit_idx    <= '0;
      byte_idx   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          if (send_request) begin
            shift_buf <= {response_value, response_command};
            byte_idx  <= 1'b0;
            busy      <= 1'b1;
            tx_serial <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            state     <= DATA;
            bit_idx   <= '0;
            tx_serial <= shift_buf[0];
            shift_buf <= shift_buf >> 1;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              state     <= STOP;
              tx_serial <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_serial <= shift_buf[0];
              shift_buf <= shift_buf >> 1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (byte_idx != LAST_BYTE) begin
              // Next byte follows with no idle gap.
              byte_idx  <= byte_idx + 1'b1;
              state     <= START;
              tx_serial <= 1'b0;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame with a 4-cycle bit period.
// Waveform-queue model, reference receiver and directed literal checks.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic       clock;
  logic       reset;
  logic       send_request;
  logic [7:0] response_command;
  logic [7:0] response_value;
  logic       busy;
  logic       tx_serial;
  logic       frame_done;

  int tests = 0;
  int fails = 0;

  uart_tx_frame #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES   (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .send_request    (send_request),
    .response_command(response_command),
    .response_value  (response_value),
    .busy            (busy),
    .tx_serial       (tx_serial),
    .frame_done      (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the line waveform of an accepted frame, one entry per cycle.
  bit mq[$];
  bit exp_tx   = 1'b1;
  bit exp_busy = 1'b0;
  bit exp_done = 1'b0;
  bit pb;
  bit started  = 1'b0;

  task automatic push_frame(input logic [7:0] c, input logic [7:0] v);
    logic [15:0] f;
    f = {v, c};
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < CPB; j++) mq.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < CPB; j++) mq.push_back(f[8*k+i]);
      for (int j = 0; j < CPB; j++) mq.push_back(1'b1);
    end
  endtask

  always @(posedge clock) begin
    pb = exp_busy;
    if (reset) begin
      mq.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else begin
      exp_done = pb && (mq.size() == 0);
      if (!pb && send_request)
        push_frame(response_command, response_value);
      if (mq.size() > 0) begin
        exp_tx   = mq.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("tx_serial", tx_serial, exp_tx);
      check("busy", busy, exp_busy);
      check("frame_done", frame_done, exp_done);
    end
  end

  int done_cnt = 0;
  always @(negedge clock)
    if (frame_done === 1'b1) done_cnt++;

  // Reference receiver: samples mid-bit, collects decoded bytes.
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  bit rx_active = 1'b0;
  int rx_c = 0;
  int rb;

  always @(negedge clock) begin
    if (reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (started && tx_serial === 1'b0) begin
        rx_active = 1'b1;
        rx_c = 0;
      end
    end else begin
      rx_c++;
      if (rx_c % CPB == CPB / 2) begin
        rb = rx_c / CPB;
        if (rb >= 1 && rb <= 8) rx_byte[rb-1] = tx_serial;
        if (rb == 9) begin
          check("rx_stop", tx_serial, 1);
          rx_q.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input string name);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check(name, found, 1);
  endtask

  logic [19:0] cap;
  logic [19:0] exp_bits;
  logic [7:0]  exp_rx [9];
  int busy_cnt;
  int done_before;

  initial begin
    reset = 1'b1;
    send_request = 1'b0;
    response_command = 8'h00;
    response_value = 8'h00;
    @(posedge clock);
    started = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Idle stretch.
    repeat (50) @(posedge clock);
    #1;
    check("idle_done_cnt", done_cnt, 0);

    // Frame 1: 0x01/0x2A; inputs change after acceptance; late request.
    send_request = 1'b1;
    response_command = 8'h01;
    response_value = 8'h2A;
    @(posedge clock);
    #1;
    send_request = 1'b0;
    response_command = 8'hFF;
    response_value = 8'h00;
    busy_cnt = 0;
    cap = '0;
    for (int i = 0; i < 80; i++) begin
      send_request = (i == 30);
      @(negedge clock);
      if (busy === 1'b1) busy_cnt++;
      if (i % CPB == 2) cap[19 - i / CPB] = tx_serial;
      @(posedge clock);
      #1;
    end
    send_request = 1'b0;
    @(negedge clock);
    #1;
    exp_bits = 20'b0100000001_0010101001;
    check("f1_bits", cap, exp_bits);
    check("f1_busy_cycles", busy_cnt, 80);
    check("f1_done_pulse", frame_done, 1);
    check("f1_busy_low", busy, 0);
    check("f1_done_cnt", done_cnt, 1);

    // Back-to-back: request in the frame_done cycle.
    @(posedge clock);
    #1;
    send_request = 1'b1;
    response_command = 8'h3C;
    response_value = 8'hC3;
    @(posedge clock);
    #1;
    send_request = 1'b0;
    wait_done("b2b_first_done");
    send_request = 1'b1;
    response_command = 8'hA5;
    response_value = 8'h5A;
    @(posedge clock);
    #1;
    send_request = 1'b0;
    @(negedge clock);
    check("b2b_start_low", tx_serial, 0);
    check("b2b_busy", busy, 1);
    wait_done("b2b_second_done");

    // Reset during byte 1 data bits.
    @(posedge clock);
    #1;
    send_request = 1'b1;
    response_command = 8'h77;
    response_value = 8'h88;
    @(posedge clock);
    #1;
    send_request = 1'b0;
    repeat (50) @(posedge clock);
    #1;
    done_before = done_cnt;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_tx_high", tx_serial, 1);
    check("rst_busy_low", busy, 0);
    repeat (100) @(negedge clock);
    check("rst_no_done", done_cnt, done_before);

    // Fresh frame after abort.
    @(posedge clock);
    #1;
    send_request = 1'b1;
    response_command = 8'h96;
    response_value = 8'h69;
    @(posedge clock);
    #1;
    send_request = 1'b0;
    wait_done("fresh_done");
    repeat (10) @(posedge clock);

    exp_rx = '{8'h01, 8'h2A, 8'h3C, 8'hC3, 8'hA5, 8'h5A,
               8'h77, 8'h96, 8'h69};
    check("rx_count", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < rx_q.size()) check("rx_byte", rx_q[i], exp_rx[i]);
      else check("rx_byte_missing", 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
